regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard for the
//  out-of-order core. NWP writeback ports with fixed priority, NRP indexed read ports with
//  optional write-to-read bypass, and a flat snapshot of all registers. Issue marks a
//  destination busy; writeback clears it; flush clears all busy bits.
//  Sits between rename/issue and the jump/mem/int writeback ports.
// PARAMETERS
//  XLEN    32  data width per register
//  NREGS   32  register count; AW = $clog2(NREGS); entry 0 is hardwired zero
//  NWP     4   writeback ports; port 0 has highest priority
//  NRP     4   indexed read ports
//  BYPASS  1   1: read ports forward same-cycle write data; 0: read returns stored value
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  wp_we_i        in   NWP         per-port write enable
//  wp_waddr_i     in   NWP*AW      per-port write address; port k occupies [k*AW +: AW]
//  wp_wdata_i     in   NWP*XLEN    per-port write data; port k occupies [k*XLEN +: XLEN]
//  alloc_we_i     in   1           issue: mark alloc_addr_i busy
//  alloc_addr_i   in   AW          destination register being allocated
//  flush_i        in   1           clear all busy bits (mispredict recovery)
//  rp_raddr_i     in   NRP*AW      read addresses, packed as for the write ports
//  rp_rdata_o     out  NRP*XLEN    read data, combinational
//  rp_busy_o      out  NRP         busy bit of each read address, combinational
//  reg_rdata_o    out  NREGS*XLEN  flat snapshot; entry r at [r*XLEN +: XLEN]; entry 0 is 0
//  busy_o         out  NREGS       registered busy vector; bit 0 is always 0
//  wr_conflict_o  out  1           registered one-cycle pulse: 2+ enabled ports hit the same nonzero addr
// BEHAVIOUR
//  Reset: every register = 0, busy_o = 0, wr_conflict_o = 0. Therefore rp_rdata_o = 0,
//    rp_busy_o = 0 and reg_rdata_o = 0 in the first cycle after reset. rst overrides all other inputs.
//  Write: on the clock edge, reg[a] <= data of the lowest-index enabled port whose addr == a.
//    Losing ports are dropped. Writes to addr 0 are ignored.
//  Conflict: wr_conflict_o = 1 in the cycle after any two enabled ports target the same nonzero addr.
//  Busy next-state, per r != 0, in priority order:
//    flush_i -> 0
//    else alloc_we_i && alloc_addr_i == r -> 1 (a same-cycle write to r still updates the data)
//    else any enabled write port targets r -> 0
//    else hold
//  alloc_we_i with alloc_addr_i == 0 has no effect. flush_i does not affect data writes.
//  Read, BYPASS=1:
//    raddr 0 -> data 0, busy 0.
//    else if an enabled write port targets raddr -> winning port's wdata, rp_busy_o = 0 (unless a
//      same-cycle alloc targets it, in which case rp_busy_o = 1).
//    else stored value and registered busy bit.
//  Read, BYPASS=0: stored value and registered busy bit; new data is visible the cycle after the write.
//  reg_rdata_o and busy_o are never bypassed (registered state only).
//  Latency: write -> storage 1 cycle; read 0 cycles (combinational).
//  Reset mid-operation: pending writes, allocs and busy state are discarded; all state returns to reset values.
// TESTING
//  1. Reset, then read x1..x31 -> all 0, busy_o = 0, wr_conflict_o = 0.
//  2. Port2 writes x5 = 0xDEADBEEF; rp0 reads x5 the same cycle.
//     -> BYPASS=1: 0xDEADBEEF that cycle. BYPASS=0: old value that cycle, 0xDEADBEEF next cycle.
//  3. Ports 0 and 3 both write x7 (0x11, 0x33).
//     -> x7 = 0x11; wr_conflict_o pulses high for exactly 1 cycle.
//  4. Alloc x9 -> busy_o[9] = 1 next cycle. Port1 writes x9 = 0x42 three cycles later.
//     -> busy_o[9] = 0 after the edge; rp_busy_o drops in the write cycle (BYPASS=1).
//  5. Alloc x4 and port0 write x4 = 0x5 in the same cycle -> x4 = 0x5, busy_o[4] = 1.
//     Alloc x6 and flush_i together -> busy_o[6] = 0.
//  6. Write x0 = 0xFFFF_FFFF and alloc x0 -> reads of x0 return 0, busy 0.
//     Assert rst mid-stream with busy bits set -> everything is 0 after one edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a per-register busy
// scoreboard. Writeback ports resolve by fixed priority (port 0 highest),
// read ports optionally forward same-cycle write data, and the full register
// contents plus the busy vector are exposed as registered state.
module regfile_mp_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NWP    = 4,
    parameter  int NRP    = 4,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWP-1:0]          wp_we_i,
    input  logic [NWP*AW-1:0]       wp_waddr_i,
    input  logic [NWP*XLEN-1:0]     wp_wdata_i,
    input  logic                    alloc_we_i,
    input  logic [AW-1:0]           alloc_addr_i,
    input  logic                    flush_i,
    input  logic [NRP*AW-1:0]       rp_raddr_i,
    output logic [NRP*XLEN-1:0]     rp_rdata_o,
    output logic [NRP-1:0]          rp_busy_o,
    output logic [NREGS*XLEN-1:0]   reg_rdata_o,
    output logic [NREGS-1:0]        busy_o,
    output logic                    wr_conflict_o
);

    logic [XLEN-1:0]  regs_q   [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             conflict_q;

    logic [NREGS-1:0] hit;
    logic [XLEN-1:0]  hit_data [NREGS];
    logic [NREGS-1:0] busy_d;
    logic             conflict_d;

    // Per register, pick the data of the lowest-index enabled port that targets it.
    always_comb begin
        hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            hit_data[r] = '0;
        end
        for (int r = 1; r < NREGS; r++) begin
            for (int k = NWP - 1; k >= 0; k--) begin
                if (wp_we_i[k] && (wp_waddr_i[k*AW +: AW] == AW'(r))) begin
                    hit[r]      = 1'b1;
                    hit_data[r] = wp_wdata_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Flag any pair of enabled ports aiming at the same nonzero register.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NWP; i++) begin
            for (int j = i + 1; j < NWP; j++) begin
                if (wp_we_i[i] && wp_we_i[j]
                    && (wp_waddr_i[i*AW +: AW] == wp_waddr_i[j*AW +: AW])
                    && (wp_waddr_i[i*AW +: AW] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Busy update: flush beats alloc, alloc beats writeback, otherwise hold.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (alloc_we_i && (alloc_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Register storage, busy vector and conflict pulse; entry 0 stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (hit[r]) begin
                    regs_q[r] <= hit_data[r];
                end
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    // Indexed reads, forwarding the winning write data when bypass is enabled.
    always_comb begin
        rp_rdata_o = '0;
        rp_busy_o  = '0;
        for (int p = 0; p < NRP; p++) begin
            if (rp_raddr_i[p*AW +: AW] != '0) begin
                if ((BYPASS != 0) && hit[rp_raddr_i[p*AW +: AW]]) begin
                    rp_rdata_o[p*XLEN +: XLEN] = hit_data[rp_raddr_i[p*AW +: AW]];
                    rp_busy_o[p] = alloc_we_i && (alloc_addr_i == rp_raddr_i[p*AW +: AW]);
                end else begin
                    rp_rdata_o[p*XLEN +: XLEN] = regs_q[rp_raddr_i[p*AW +: AW]];
                    rp_busy_o[p] = busy_q[rp_raddr_i[p*AW +: AW]];
                end
            end
        end
    end

    // Flat snapshot of stored contents; never forwarded.
    always_comb begin
        reg_rdata_o = '0;
        for (int r = 1; r < NREGS; r++) begin
            reg_rdata_o[r*XLEN +: XLEN] = regs_q[r];
        end
    end

    assign busy_o        = busy_q;
    assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: the stimulus process queues expected
// values tagged with the cycle they belong to, and a monitor process samples
// the outputs mid-cycle and retires every queued entry for that cycle.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NWP   = 4;
    localparam int NRP   = 4;
    localparam int AW    = 5;

    localparam int K_RDATA = 0;
    localparam int K_RBUSY = 1;
    localparam int K_NBRD  = 2;
    localparam int K_BUSY  = 3;
    localparam int K_CONF  = 4;
    localparam int K_SNAP  = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NWP-1:0]        we = '0;
    logic [NWP*AW-1:0]     waddr = '0;
    logic [NWP*XLEN-1:0]   wdata = '0;
    logic                  alloc_we = 1'b0;
    logic [AW-1:0]         alloc_addr = '0;
    logic                  flush = 1'b0;
    logic [NRP*AW-1:0]     raddr = '0;

    logic [NRP*XLEN-1:0]   rdata;
    logic [NRP-1:0]        rbusy;
    logic [NREGS*XLEN-1:0] snap;
    logic [NREGS-1:0]      busy;
    logic                  conflict;

    logic [NRP*XLEN-1:0]   nb_rdata;
    logic [NRP-1:0]        nb_rbusy;
    logic [NREGS*XLEN-1:0] nb_snap;
    logic [NREGS-1:0]      nb_busy;
    logic                  nb_conflict;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NWP(NWP), .NRP(NRP), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .wp_we_i(we), .wp_waddr_i(waddr), .wp_wdata_i(wdata),
        .alloc_we_i(alloc_we), .alloc_addr_i(alloc_addr), .flush_i(flush),
        .rp_raddr_i(raddr), .rp_rdata_o(rdata), .rp_busy_o(rbusy),
        .reg_rdata_o(snap), .busy_o(busy), .wr_conflict_o(conflict)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NWP(NWP), .NRP(NRP), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .wp_we_i(we), .wp_waddr_i(waddr), .wp_wdata_i(wdata),
        .alloc_we_i(alloc_we), .alloc_addr_i(alloc_addr), .flush_i(flush),
        .rp_raddr_i(raddr), .rp_rdata_o(nb_rdata), .rp_busy_o(nb_rbusy),
        .reg_rdata_o(nb_snap), .busy_o(nb_busy), .wr_conflict_o(nb_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic string kname(int k);
        case (k)
            K_RDATA: return "rp_rdata";
            K_RBUSY: return "rp_busy";
            K_NBRD:  return "nobypass_rdata";
            K_BUSY:  return "busy_o";
            K_CONF:  return "wr_conflict";
            default: return "reg_rdata";
        endcase
    endfunction

    function automatic logic [31:0] actual(int k, int idx);
        case (k)
            K_RDATA: return rdata[idx*XLEN +: XLEN];
            K_RBUSY: return {31'b0, rbusy[idx]};
            K_NBRD:  return nb_rdata[idx*XLEN +: XLEN];
            K_BUSY:  return busy;
            K_CONF:  return {31'b0, conflict};
            default: return snap[idx*XLEN +: XLEN];
        endcase
    endfunction

    // Monitor: sample mid-cycle and retire all expectations for this cycle.
    initial begin
        forever begin
            int i;
            logic [31:0] act;
            @(negedge clk);
            #2;
            i = 0;
            while (i < sb_q.size()) begin
                if (sb_q[i].cyc == cyc) begin
                    act = actual(sb_q[i].kind, sb_q[i].idx);
                    tests_run++;
                    if (act !== sb_q[i].exp) begin
                        tests_failed++;
                        $display("FAIL %s[%0d] cyc %0d: got %h expected %h",
                                 kname(sb_q[i].kind), sb_q[i].idx, cyc, act, sb_q[i].exp);
                    end
                    sb_q.delete(i);
                end else if (sb_q[i].cyc < cyc) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL %s[%0d] never sampled (due cyc %0d)",
                             kname(sb_q[i].kind), sb_q[i].idx, sb_q[i].cyc);
                    sb_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_cycle();
        @(negedge clk);
        we         = '0;
        waddr      = '0;
        wdata      = '0;
        alloc_we   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
        raddr      = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        we[p]              = 1'b1;
        waddr[p*AW +: AW]  = AW'(a);
        wdata[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic alloc(input int a);
        alloc_we   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    task automatic chk(input int kind, input int idx, input logic [31:0] e);
        exp_t item;
        item.cyc  = cyc;
        item.kind = kind;
        item.idx  = idx;
        item.exp  = e;
        sb_q.push_back(item);
    endtask

    // Stimulus: one directed vector per cycle with hand-computed expectations.
    initial begin
        start_cycle();
        rst = 1'b1;
        start_cycle();
        rst = 1'b1;

        // Reset state: every register reads zero and nothing is busy.
        for (int w = 0; w < 8; w++) begin
            start_cycle();
            rst = 1'b0;
            for (int p = 0; p < NRP; p++) begin
                rd(p, w * 4 + p);
                chk(K_RDATA, p, 32'h0);
                chk(K_RBUSY, p, 32'h0);
                chk(K_NBRD, p, 32'h0);
            end
            if (w == 0) begin
                chk(K_BUSY, 0, 32'h0);
                chk(K_CONF, 0, 32'h0);
                for (int r = 0; r < NREGS; r++) chk(K_SNAP, r, 32'h0);
            end
        end

        // Bypass vs stored read of a fresh write.
        start_cycle();
        wr(2, 5, 32'hDEADBEEF);
        rd(0, 5);
        chk(K_RDATA, 0, 32'hDEADBEEF);
        chk(K_NBRD, 0, 32'h0);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_SNAP, 5, 32'h0);
        start_cycle();
        rd(0, 5);
        chk(K_RDATA, 0, 32'hDEADBEEF);
        chk(K_NBRD, 0, 32'hDEADBEEF);
        chk(K_SNAP, 5, 32'hDEADBEEF);

        // Port 0 and 3 collide on x7; port 1 and 2 collide on x20.
        start_cycle();
        wr(0, 7, 32'h11);
        wr(3, 7, 32'h33);
        rd(1, 7);
        chk(K_RDATA, 1, 32'h11);
        chk(K_CONF, 0, 32'h0);
        start_cycle();
        rd(1, 7);
        chk(K_RDATA, 1, 32'h11);
        chk(K_NBRD, 1, 32'h11);
        chk(K_SNAP, 7, 32'h11);
        chk(K_CONF, 0, 32'h1);
        start_cycle();
        wr(1, 20, 32'hAA);
        wr(2, 20, 32'hBB);
        wr(3, 21, 32'h3333);
        rd(2, 20);
        rd(3, 21);
        chk(K_RDATA, 2, 32'hAA);
        chk(K_RDATA, 3, 32'h3333);
        chk(K_CONF, 0, 32'h0);
        start_cycle();
        wr(0, 22, 32'h2222);
        wr(1, 23, 32'h2323);
        chk(K_CONF, 0, 32'h1);
        chk(K_SNAP, 20, 32'hAA);
        chk(K_SNAP, 21, 32'h3333);
        start_cycle();
        chk(K_CONF, 0, 32'h0);
        chk(K_SNAP, 22, 32'h2222);
        chk(K_SNAP, 23, 32'h2323);

        // Alloc x9, writeback three cycles later clears busy.
        start_cycle();
        alloc(9);
        rd(0, 9);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_BUSY, 0, 32'h0);
        start_cycle();
        rd(0, 9);
        chk(K_RBUSY, 0, 32'h1);
        chk(K_BUSY, 0, 32'h0000_0200);
        start_cycle();
        rd(0, 9);
        chk(K_BUSY, 0, 32'h0000_0200);
        start_cycle();
        wr(1, 9, 32'h42);
        rd(0, 9);
        chk(K_RDATA, 0, 32'h42);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_NBRD, 0, 32'h0);
        chk(K_BUSY, 0, 32'h0000_0200);
        start_cycle();
        rd(0, 9);
        chk(K_RDATA, 0, 32'h42);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_BUSY, 0, 32'h0);

        // Alloc wins over a same-cycle write; flush wins over alloc.
        start_cycle();
        alloc(4);
        wr(0, 4, 32'h5);
        rd(0, 4);
        chk(K_RDATA, 0, 32'h5);
        chk(K_RBUSY, 0, 32'h1);
        start_cycle();
        alloc(6);
        flush = 1'b1;
        wr(2, 8, 32'h88);
        rd(0, 4);
        chk(K_RDATA, 0, 32'h5);
        chk(K_RBUSY, 0, 32'h1);
        chk(K_BUSY, 0, 32'h0000_0010);
        start_cycle();
        rd(1, 6);
        chk(K_BUSY, 0, 32'h0);
        chk(K_RBUSY, 1, 32'h0);
        chk(K_SNAP, 4, 32'h5);
        chk(K_SNAP, 8, 32'h88);

        // Register 0 ignores writes and allocs; two writes to x0 are no conflict.
        start_cycle();
        wr(0, 0, 32'hFFFF_FFFF);
        wr(1, 0, 32'h1234_5678);
        alloc(0);
        rd(0, 0);
        rd(1, 0);
        chk(K_RDATA, 0, 32'h0);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_RDATA, 1, 32'h0);
        start_cycle();
        rd(0, 0);
        chk(K_RDATA, 0, 32'h0);
        chk(K_RBUSY, 0, 32'h0);
        chk(K_BUSY, 0, 32'h0);
        chk(K_CONF, 0, 32'h0);
        chk(K_SNAP, 0, 32'h0);

        // Reset in the middle of traffic discards everything.
        start_cycle();
        alloc(10);
        start_cycle();
        alloc(11);
        wr(0, 12, 32'h1234);
        rd(2, 10);
        chk(K_RBUSY, 2, 32'h1);
        start_cycle();
        rst = 1'b1;
        alloc(13);
        wr(1, 14, 32'h77);
        wr(2, 15, 32'h1);
        wr(3, 15, 32'h2);
        rd(0, 12);
        chk(K_RDATA, 0, 32'h1234);
        chk(K_BUSY, 0, 32'h0000_0C00);
        start_cycle();
        rst = 1'b0;
        rd(0, 12);
        rd(1, 14);
        rd(2, 10);
        rd(3, 13);
        for (int p = 0; p < NRP; p++) begin
            chk(K_RDATA, p, 32'h0);
            chk(K_RBUSY, p, 32'h0);
        end
        chk(K_BUSY, 0, 32'h0);
        chk(K_CONF, 0, 32'h0);
        chk(K_SNAP, 5, 32'h0);
        chk(K_SNAP, 12, 32'h0);
        chk(K_SNAP, 14, 32'h0);
        chk(K_SNAP, 15, 32'h0);

        start_cycle();
        start_cycle();
        start_cycle();
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
            tests_run    += sb_q.size();
            tests_failed += sb_q.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
